// File: rtl/cpu_mdu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_mdu_pkg
// Shared definitions for the M-extension sequencer and its cpu_mdu partner:
//   - mdu_state_e : sequencer FSM states
//   - MDU_*       : 3-bit MDU operation codes (RISC-V funct3 ordering)
// -----------------------------------------------------------------------------
package cpu_mdu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      WB    = 2'd3
   } mdu_state_e;

   localparam logic [2:0] MDU_MUL    = 3'd0;
   localparam logic [2:0] MDU_MULH   = 3'd1;
   localparam logic [2:0] MDU_MULHSU = 3'd2;
   localparam logic [2:0] MDU_MULHU  = 3'd3;
   localparam logic [2:0] MDU_DIV    = 3'd4;
   localparam logic [2:0] MDU_DIVU   = 3'd5;
   localparam logic [2:0] MDU_REM    = 3'd6;
   localparam logic [2:0] MDU_REMU   = 3'd7;

endpackage

// File: rtl/cpu_mdu_seq.sv
// -----------------------------------------------------------------------------
// cpu_mdu_seq
// Sequences one M-extension op at a time between the execute stage, an external
// (non-abortable) cpu_mdu and the writeback port.
//
// Parameters : XLEN (operand/result width), RD_W (destination index width)
// Ports:
//   clk, reset                  rising-edge clock, async active-high reset
//   in_valid/in_ready           op handshake from execute (ready only in IDLE)
//   in_control/in_a/in_b/in_rd  MDU_* opcode, operands, destination register
//   mdu_start                   start request, held for the whole ISSUE state
//   mdu_operand_a/_b, mdu_control  registered operands to cpu_mdu
//   mdu_result/mdu_ready        cpu_mdu result and done
//   wb_valid/wb_ready           writeback handshake
//   wb_rd/wb_data               writeback register and value (result unmodified)
//   flush                       discard the in-flight op
//   busy                        high whenever the FSM is not IDLE
//
// Optional feature (macro CPU_MDU_REUSE_EN): remembers the last completed
// (control, a, b, result) tuple; an identical op goes straight to WB without
// touching cpu_mdu.
// -----------------------------------------------------------------------------
module cpu_mdu_seq
   import cpu_mdu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_control,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic [RD_W-1:0] in_rd,
   output logic            mdu_start,
   output logic [XLEN-1:0] mdu_operand_a,
   output logic [XLEN-1:0] mdu_operand_b,
   output logic [2:0]      mdu_control,
   input  logic [XLEN-1:0] mdu_result,
   input  logic            mdu_ready,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [RD_W-1:0] wb_rd,
   output logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            busy
);

   mdu_state_e      state_q, state_d;
   logic            kill_q;
   logic            accept;
   logic            drain_done;
   logic            reuse_hit;
   logic [XLEN-1:0] reuse_data;

   assign accept     = (state_q == IDLE) && in_valid && !flush;
   // cpu_mdu has released ready, so a following start cannot see a stale done
   assign drain_done = (state_q == DRAIN) && !mdu_ready;

`ifdef CPU_MDU_REUSE_EN
   logic            c_vld;
   logic [2:0]      c_ctrl;
   logic [XLEN-1:0] c_a, c_b, c_res;

   assign reuse_hit  = c_vld && (in_control == c_ctrl) && (in_a == c_a) && (in_b == c_b);
   assign reuse_data = c_res;

   // Tuple is recorded when an op finishes its handshake un-killed; any flush
   // or killed op invalidates it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         c_vld  <= 1'b0;
         c_ctrl <= '0;
         c_a    <= '0;
         c_b    <= '0;
         c_res  <= '0;
      end else if (flush) begin
         c_vld <= 1'b0;
      end else if (drain_done) begin
         c_vld  <= !kill_q;
         c_ctrl <= mdu_control;
         c_a    <= mdu_operand_a;
         c_b    <= mdu_operand_b;
         c_res  <= wb_data;
      end
   end
`else
   assign reuse_hit  = 1'b0;
   assign reuse_data = '0;
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = reuse_hit ? WB : ISSUE;
         ISSUE:   if (mdu_ready) state_d = DRAIN;
         // a flush arriving on the exit cycle kills the op just like an earlier one
         DRAIN:   if (!mdu_ready) state_d = (kill_q || flush) ? IDLE : WB;
         WB:      if (flush || wb_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      in_ready  = (state_q == IDLE);
      mdu_start = (state_q == ISSUE);
      wb_valid  = (state_q == WB);
      busy      = (state_q != IDLE);
   end

   // Operand, destination and result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mdu_operand_a <= '0;
         mdu_operand_b <= '0;
         mdu_control   <= '0;
         wb_rd         <= '0;
         wb_data       <= '0;
      end else begin
         if (accept) begin
            mdu_operand_a <= in_a;
            mdu_operand_b <= in_b;
            mdu_control   <= in_control;
            wb_rd         <= in_rd;
            if (reuse_hit) wb_data <= reuse_data;
         end
         if ((state_q == ISSUE) && mdu_ready) wb_data <= mdu_result;
      end
   end

   // Kill flag: remembers a flush seen while cpu_mdu is still busy with the op
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         kill_q <= 1'b0;
      end else if (drain_done) begin
         kill_q <= 1'b0;
      end else if (((state_q == ISSUE) || (state_q == DRAIN)) && flush) begin
         kill_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cpu_mdu_seq.sv
module tb_cpu_mdu_seq;
   import cpu_mdu_pkg::*;

   localparam int XLEN = 32;
   localparam int RD_W = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid, in_ready;
   logic [2:0]      in_control;
   logic [XLEN-1:0] in_a, in_b;
   logic [RD_W-1:0] in_rd;
   logic            mdu_start;
   logic [XLEN-1:0] mdu_operand_a, mdu_operand_b;
   logic [2:0]      mdu_control;
   logic [XLEN-1:0] mdu_result = '0;
   logic            mdu_ready = 1'b0;
   logic            wb_valid, wb_ready;
   logic [RD_W-1:0] wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            flush, busy;

   always #5 clk = ~clk;

   cpu_mdu_seq #(.XLEN(XLEN), .RD_W(RD_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_control(in_control),
      .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
      .mdu_start(mdu_start), .mdu_operand_a(mdu_operand_a),
      .mdu_operand_b(mdu_operand_b), .mdu_control(mdu_control),
      .mdu_result(mdu_result), .mdu_ready(mdu_ready),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush), .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", tag, act, exp);
      end
   endtask

   // Architectural M-extension results (RISC-V semantics incl. div-by-zero/overflow)
   function automatic logic [XLEN-1:0] ref_mdu(input logic [2:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
      logic signed [2*XLEN-1:0] sa, sb, za, zb, p;
      logic signed [XLEN-1:0]   qa, qb;
      logic [XLEN-1:0]          minv;
      minv = {1'b1, {(XLEN-1){1'b0}}};
      sa = {{XLEN{a[XLEN-1]}}, a};
      sb = {{XLEN{b[XLEN-1]}}, b};
      za = {{XLEN{1'b0}}, a};
      zb = {{XLEN{1'b0}}, b};
      qa = a;
      qb = b;
      case (op)
         MDU_MUL:    begin p = sa * sb; return p[XLEN-1:0]; end
         MDU_MULH:   begin p = sa * sb; return p[2*XLEN-1:XLEN]; end
         MDU_MULHSU: begin p = sa * zb; return p[2*XLEN-1:XLEN]; end
         MDU_MULHU:  begin p = za * zb; return p[2*XLEN-1:XLEN]; end
         MDU_DIV: begin
            if (b == '0) return '1;
            if (a == minv && b == '1) return a;
            return qa / qb;
         end
         MDU_DIVU: begin
            if (b == '0) return '1;
            return a / b;
         end
         MDU_REM: begin
            if (b == '0) return a;
            if (a == minv && b == '1) return '0;
            return qa % qb;
         end
         default: begin
            if (b == '0) return a;
            return a % b;
         end
      endcase
   endfunction

   // Stand-in cpu_mdu: ready rises m_lat cycles after start is first seen and
   // stays high for m_hold cycles.
   int              m_lat = 1, m_hold = 1, m_phase = 0, m_t = 0, n_starts = 0;
   logic [XLEN-1:0] m_a, m_b;
   logic [2:0]      m_c;

   always @(negedge clk) begin
      if (reset) begin
         mdu_ready = 1'b0;
         m_phase   = 0;
      end else begin
         case (m_phase)
            0: if (mdu_start) begin
                  n_starts++;
                  m_a = mdu_operand_a; m_b = mdu_operand_b; m_c = mdu_control;
                  m_t = 0;
                  m_phase = 1;
                  if (m_lat == 0) begin
                     mdu_ready = 1'b1; mdu_result = ref_mdu(m_c, m_a, m_b);
                     m_phase = 2; m_t = 0;
                  end
               end
            1: begin
                  check_eq("start_held", mdu_start, 1);
                  check_eq("opnd_stable", (mdu_operand_a !== m_a || mdu_operand_b !== m_b ||
                                           mdu_control !== m_c), 0);
                  m_t++;
                  if (m_t >= m_lat) begin
                     mdu_ready = 1'b1; mdu_result = ref_mdu(m_c, m_a, m_b);
                     m_phase = 2; m_t = 0;
                  end
               end
            default: begin
                  check_eq("start_drop", mdu_start, 0);
                  m_t++;
                  if (m_t >= m_hold) begin
                     mdu_ready = 1'b0;
                     m_phase = 0;
                  end
               end
         endcase
      end
   end

   // Reuse-cache view kept by the bench (only consulted with CPU_MDU_REUSE_EN)
   logic            last_vld = 1'b0;
   logic [2:0]      last_c;
   logic [XLEN-1:0] last_a, last_b;

   // One op end to end. flush_at: cycle after acceptance in which flush is
   // pulsed (0 = never). stall: extra WB cycles with wb_ready low.
   task automatic do_op(input logic [2:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [RD_W-1:0] rd, input int lat, input int hold,
                        input int stall, input int flush_at);
      logic [XLEN-1:0] exp_data;
      bit hit, killed, flush_in_wb;
      int wbc, last_cycle, s0;
      exp_data = ref_mdu(c, a, b);
      hit = 1'b0;
`ifdef CPU_MDU_REUSE_EN
      hit = last_vld && last_c == c && last_a == a && last_b == b;
`endif
      wbc         = hit ? 1 : lat + hold + 2;
      killed      = (flush_at >= 1) && (flush_at < wbc);
      flush_in_wb = (flush_at >= wbc) && (flush_at <= wbc + stall);
      last_cycle  = killed ? wbc : (flush_in_wb ? flush_at + 1 : wbc + stall + 1);
      m_lat = lat; m_hold = hold;
      s0 = n_starts;

      @(posedge clk); #1;
      in_valid = 1'b1; in_control = c; in_a = a; in_b = b; in_rd = rd;
      flush = 1'b0; wb_ready = 1'b0;
      @(negedge clk);
      check_eq("accept_ready", in_ready, 1);
      for (int cyc = 1; cyc <= last_cycle; cyc++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         flush    = (cyc == flush_at);
         wb_ready = !killed && !flush_in_wb && (cyc == wbc + stall);
         @(negedge clk);
         if (cyc == last_cycle) begin
            check_eq("end_in_ready", in_ready, 1);
            check_eq("end_wb_valid", wb_valid, 0);
            check_eq("end_busy", busy, 0);
         end else if (cyc < wbc) begin
            check_eq("pre_wb_valid", wb_valid, 0);
            check_eq("busy_in_ready", in_ready, 0);
            check_eq("busy", busy, 1);
         end else begin
            check_eq("wb_valid", wb_valid, 1);
            check_eq("wb_data", wb_data, exp_data);
            check_eq("wb_rd", wb_rd, rd);
            check_eq("wb_in_ready", in_ready, 0);
         end
      end
      #1;
      flush = 1'b0; wb_ready = 1'b0;
      check_eq("start_count", n_starts - s0, hit ? 0 : 1);
      if (!killed) begin
         last_vld = 1'b1; last_c = c; last_a = a; last_b = b;
      end
      if (flush_at > 0) last_vld = 1'b0;
   endtask

   function automatic logic [XLEN-1:0] pick_operand();
      logic [XLEN-1:0] v;
      case ($urandom_range(0, 9))
         0: v = '0;
         1: v = 1;
         2: v = '1;
         3: v = {1'b1, {(XLEN-1){1'b0}}};
         4: v = $urandom_range(0, 15);
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      logic [2:0]      rc;
      logic [XLEN-1:0] ra, rb;
      int lat, hold, stall, fa, wbc;

      reset = 1'b1; in_valid = 1'b0; in_control = '0; in_a = '0; in_b = '0;
      in_rd = '0; wb_ready = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_start", mdu_start, 0);
      check_eq("rst_wb_valid", wb_valid, 0);
      check_eq("rst_wb_data", wb_data, 0);
      check_eq("rst_wb_rd", wb_rd, 0);
      check_eq("rst_opnd_a", mdu_operand_a, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Directed cases
      do_op(MDU_MUL,   2, 3, 5, 1, 1, 0, 0);
      do_op(MDU_MULHU, '1, 2, 7, 2, 1, 0, 0);
      do_op(MDU_DIV,   1, 0, 9, 3, 2, 0, 0);
      do_op(MDU_DIV,   6, 3, 4, 2, 1, 0, 2);     // killed in flight
      do_op(MDU_MUL,   2, 3, 5, 1, 1, 5, 0);     // writeback stalled 5 cycles
      do_op(MDU_MUL,   4, 5, 3, 0, 1, 3, 4);     // flushed while in WB
      do_op(MDU_REM,   7, 3, 2, 1, 1, 0, 0);
      do_op(MDU_REM,   7, 3, 2, 1, 1, 0, 0);     // cache hit when reuse is built in

      // flush together with in_valid in IDLE must not accept
      @(posedge clk); #1;
      in_valid = 1'b1; flush = 1'b1; in_control = MDU_MUL; in_a = 9; in_b = 9; in_rd = 1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check_eq("flush_idle_ready", in_ready, 1);
      check_eq("flush_idle_busy", busy, 0);
      last_vld = 1'b0;

      // Asynchronous reset in the middle of ISSUE
      m_lat = 3; m_hold = 1;
      @(posedge clk); #1;
      in_valid = 1'b1; in_control = MDU_MUL; in_a = 11; in_b = 13; in_rd = 6;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_eq("issue_start", mdu_start, 1);
      #2 reset = 1'b1;
      #1;
      check_eq("async_rst_start", mdu_start, 0);
      check_eq("async_rst_busy", busy, 0);
      check_eq("async_rst_opnd", mdu_operand_a, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      last_vld = 1'b0;

      // Randomised ops
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 4) != 0 || n == 0) begin
            rc = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
         end
         lat   = $urandom_range(0, 3);
         hold  = $urandom_range(1, 2);
         stall = $urandom_range(0, 3);
         wbc   = lat + hold + 2;
         fa    = 0;
         if ($urandom_range(0, 4) == 0) fa = $urandom_range(1, wbc + stall);
`ifdef CPU_MDU_REUSE_EN
         if (last_vld && last_c == rc && last_a == ra && last_b == rb) fa = 0;
`endif
         do_op(rc, ra, rb, RD_W'($urandom), lat, hold, stall, fa);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
